wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Parametrised Wishbone B4 pipelined arbiter that merges NCH CPU-side master channels onto the single Wishbone bus in front of wb_mem.
- Typical channels are the I-cache and D-cache refill ports; NCH generalises to N channels.
- Adds round-robin or fixed-priority arbitration, bus ownership per cycle (cyc), and bounded outstanding-request tracking.

Parameters:
- AW, 12, word-address width of the Wishbone bus.
- NCH, 2, number of master channels (2..8).
- MAX_OUT, 4, maximum accepted-but-unacknowledged requests for the granted master (1..15).
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- cpu_clock_i, in, 1, clock; all state updates on the rising edge.
- cpu_reset_i, in, 1, synchronous active-high reset.
- m_cyc_i, in, NCH, per-master cycle request.
- m_stb_i, in, NCH, per-master strobe.
- m_we_i, in, NCH, per-master write enable.
- m_adr_i, in, NCH*AW, per-master address; channel k occupies bits [k*AW +: AW].
- m_dat_i, in, NCH*32, per-master write data; channel k occupies [k*32 +: 32].
- m_sel_i, in, NCH*4, per-master byte selects; channel k occupies [k*4 +: 4].
- m_stall_o, out, NCH, per-master stall.
- m_ack_o, out, NCH, per-master acknowledge.
- m_err_o, out, NCH, per-master error.
- m_dat_o, out, 32, read data shared by all masters; valid only with that master's ack.
- wb_cyc_o, out, 1, slave-side cycle.
- wb_stb_o, out, 1, slave-side strobe.
- wb_we_o, out, 1, slave-side write enable.
- wb_adr_o, out, AW, slave-side address.
- wb_dat_o, out, 32, slave-side write data.
- wb_sel_o, out, 4, slave-side byte selects.
- wb_stall_i, in, 1, slave stall.
- wb_ack_i, in, 1, slave acknowledge.
- wb_dat_i, in, 32, slave read data.
- wb_err_i, in, 1, slave error.

Behaviour:
- Reset values:
  - Arbiter state is IDLE.
  - Grant register g = 0.
  - Last-grant pointer = NCH-1, so channel 0 wins first.
  - Outstanding counter cnt = 0.
  - In IDLE: wb_cyc_o = 0, wb_stb_o = 0, m_stall_o = all 1, m_ack_o = 0, m_err_o = 0.
- State IDLE:
  - All masters see stall = 1, ack = 0, err = 0; slave cyc and stb are 0.
  - If any m_cyc_i bit is set, select a winner and load it into g.
    - RR = 1: search starts at last+1, wraps modulo NCH.
    - RR = 0: lowest set index wins.
  - Next state is OWNED. Arbitration latency is 1 cycle: a master raising cyc at edge N sees stall drop at earliest in cycle N+1.
- State OWNED (granted master g):
  - wb_cyc_o = m_cyc_i[g].
  - wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o are a combinational mux of channel g.
  - full = (cnt == MAX_OUT).
  - wb_stb_o = m_stb_i[g] & m_cyc_i[g] & !full.
  - m_stall_o[g] = wb_stall_i | full; all other masters stall = 1.
  - m_ack_o[g] = wb_ack_i & (cnt != 0); m_err_o[g] likewise with wb_err_i. Other channels' ack and err are 0.
  - m_dat_o = wb_dat_i.
  - accept = wb_stb_o & !wb_stall_i.
  - retire = (wb_ack_i | wb_err_i) & (cnt != 0).
  - cnt next = cnt + accept - retire. Accept and retire in the same cycle leave cnt unchanged.
- Release:
  - When m_cyc_i[g] = 0 in OWNED: next state IDLE, cnt is cleared to 0, last = g.
  - wb_cyc_o is 0 combinationally in that cycle. The earliest new grant is 1 cycle later.
  - Outstanding responses are abandoned (standard Wishbone abort); late acks in IDLE are not forwarded.
- Boundary conditions:
  - Spurious ack/err with cnt = 0: dropped, cnt stays 0.
  - err counts as a retire exactly like ack.
  - Counter saturation is impossible: accept is blocked by full.
  - A master dropping cyc with cnt > 0 is legal (abort).
  - NCH = 1 degenerates to pass-through with the 1-cycle grant latency still present.
  - Reset asserted mid-OWNED: on that edge, state becomes IDLE with cnt = 0 and last = NCH-1. wb_cyc_o is 0 from the cycle after the edge.

Test Plan:
- Single master read:
  - Stimulus: ch0 cyc/stb, adr 0x010; wb_mem acks with data 0xDEADBEEF.
  - Response: stall drops 1 cycle after cyc; wb_adr_o = 0x010; m_ack_o = 01; m_dat_o = 0xDEADBEEF; IDLE after ch0 drops cyc.
- RR fairness:
  - Stimulus: RR = 1; ch0 and ch1 hold cyc continuously, each releasing after 1 transfer.
  - Response: grant order 0,1,0,1; the non-granted channel always sees stall = 1 and ack = 0.
- Fixed priority:
  - Stimulus: RR = 0; ch1 requests at cycle 0, ch0 at cycle 0.
  - Response: ch0 is granted first; ch1 is granted only after ch0 drops cyc.
- Outstanding limit:
  - Stimulus: MAX_OUT = 2; ch0 issues 4 back-to-back stb; slave delays acks 5 cycles.
  - Response: exactly 2 strobes accepted; m_stall_o[0] = 1 until the first ack, after which the third request is accepted on the cycle following that ack.
- Error/abort:
  - Stimulus: wb_err_i on the 2nd of 3 requests.
  - Response: m_err_o[0] pulses once. Master then drops cyc with cnt = 1, and a late ack on the following cycle produces no m_ack_o.
- Reset mid-transaction:
  - Stimulus: assert cpu_reset_i for 1 cycle while ch1 owns the bus with cnt = 2.
  - Response: after the edge, wb_cyc_o = 0 and all m_stall_o = 1. The next simultaneous ch0/ch1 request grants ch0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Wishbone B4 pipelined arbiter: merges NCH master channels onto one slave bus.
// The grant is held until the owning master drops cyc, and the number of outstanding requests is bounded by MAX_OUT.
module wb_rr_arbiter #(
  parameter int AW      = 12,
  parameter int NCH     = 2,
  parameter int MAX_OUT = 4,
  parameter int RR      = 1
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_i,
  input  logic [NCH-1:0]    m_cyc_i,
  input  logic [NCH-1:0]    m_stb_i,
  input  logic [NCH-1:0]    m_we_i,
  input  logic [NCH*AW-1:0] m_adr_i,
  input  logic [NCH*32-1:0] m_dat_i,
  input  logic [NCH*4-1:0]  m_sel_i,
  output logic [NCH-1:0]    m_stall_o,
  output logic [NCH-1:0]    m_ack_o,
  output logic [NCH-1:0]    m_err_o,
  output logic [31:0]       m_dat_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_stall_i,
  input  logic              wb_ack_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_err_i
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t        state_q;
  logic [GW-1:0] g_q;
  logic [GW-1:0] last_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [GW-1:0] win_d;
  logic          found;
  int            scan_idx;

  logic owned;
  logic sel_cyc;
  logic sel_stb;
  logic full;
  logic busy_cnt;
  logic accept;
  logic retire;

  // Winner search: round-robin starts just after the last owner, fixed priority starts at 0.
  always_comb begin
    win_d    = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = (RR != 0) ? ((int'(last_q) + 1 + i) % NCH) : i;
      if (!found && m_cyc_i[scan_idx]) begin
        win_d = GW'(scan_idx);
        found = 1'b1;
      end
    end
  end

  assign owned    = (state_q == ST_OWNED);
  assign sel_cyc  = m_cyc_i[g_q];
  assign sel_stb  = m_stb_i[g_q];
  assign full     = (cnt_q == CW'(MAX_OUT));
  assign busy_cnt = (cnt_q != '0);

  assign wb_cyc_o = owned & sel_cyc;
  assign wb_stb_o = owned & sel_cyc & sel_stb & ~full;
  assign wb_we_o  = m_we_i[g_q];
  assign wb_adr_o = m_adr_i[int'(g_q)*AW +: AW];
  assign wb_dat_o = m_dat_i[int'(g_q)*32 +: 32];
  assign wb_sel_o = m_sel_i[int'(g_q)*4 +: 4];
  assign m_dat_o  = wb_dat_i;

  assign accept = wb_stb_o & ~wb_stall_i;
  // Responses with nothing outstanding are strays from an aborted cycle.
  assign retire = owned & (wb_ack_i | wb_err_i) & busy_cnt;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic mine;
      assign mine          = owned && (g_q == GW'(gi));
      assign m_stall_o[gi] = mine ? (wb_stall_i | full) : 1'b1;
      assign m_ack_o[gi]   = mine & wb_ack_i & busy_cnt;
      assign m_err_o[gi]   = mine & wb_err_i & busy_cnt;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      last_q  <= GW'(NCH - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|m_cyc_i) begin
            g_q     <= win_d;
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          // Dropping cyc aborts the cycle; any outstanding responses are forgotten.
          if (!sel_cyc) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= g_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: per-cycle vector table, scoreboarded auto master/slave runs,
// and hand-written abort, reset and fixed-priority sequences.
module tb_wb_rr_arbiter;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [23:0] m_adr;
  logic [63:0] m_dat;
  logic [7:0]  m_sel;
  logic [1:0]  m_stall, m_ack, m_err;
  logic [31:0] m_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [11:0] wb_adr;
  logic [31:0] wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_ack, wb_err;
  logic [31:0] wb_rdat;

  logic [1:0]  fp_cyc, fp_stb;
  logic [1:0]  fp_stall, fp_ack, fp_err;
  logic [31:0] fp_mdat;
  logic        fp_wcyc, fp_wstb, fp_wwe;
  logic [11:0] fp_wadr;
  logic [31:0] fp_wdat;
  logic [3:0]  fp_wsel;

  wb_rr_arbiter #(.AW(AW), .NCH(2), .MAX_OUT(2), .RR(1)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_stall_o(m_stall), .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_wdat), .wb_sel_o(wb_sel),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_dat_i(wb_rdat), .wb_err_i(wb_err)
  );

  wb_rr_arbiter #(.AW(AW), .NCH(2), .MAX_OUT(2), .RR(0)) dut_fp (
    .cpu_clock_i(clk), .cpu_reset_i(rst),
    .m_cyc_i(fp_cyc), .m_stb_i(fp_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_stall_o(fp_stall), .m_ack_o(fp_ack), .m_err_o(fp_err), .m_dat_o(fp_mdat),
    .wb_cyc_o(fp_wcyc), .wb_stb_o(fp_wstb), .wb_we_o(fp_wwe), .wb_adr_o(fp_wadr),
    .wb_dat_o(fp_wdat), .wb_sel_o(fp_wsel),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_dat_i(wb_rdat), .wb_err_i(wb_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [11:0] a);
    return 32'hC0DE0000 | {20'h0, a};
  endfunction

  // One row per clock: channel-0 and slave inputs, then the outputs required in that cycle.
  typedef struct {
    logic        cyc0, stb0, we0;
    logic [11:0] adr0;
    logic        wstall, wack, werr;
    logic [31:0] wdat;
    logic        e_cyc, e_stb;
    logic [1:0]  e_stall, e_ack, e_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];
  vec_t v;

  typedef struct { int due; logic [31:0] dat; } rsp_t;
  typedef struct { int ch;  logic [31:0] dat; } exp_t;
  rsp_t rsp_q[$];
  exp_t sb_q[$];
  int   grant_log[$];
  int   acc_log[$];
  int   ack_log[$];
  logic stall_log[$];

  int          cur = 0;
  int          base = 0;
  bit          auto_m = 0;
  bit          slave_auto = 0;
  int          slave_delay = 1;
  int          nreq = 1;
  int          jobs[2];
  int          rem[2];
  int          pend[2];
  bit          busy[2];
  bit          first_acc[2];
  logic [11:0] madr[2];

  task automatic next();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic drive_all();
    if (auto_m) begin
      for (int k = 0; k < 2; k++) begin
        if (busy[k] && rem[k] == 0 && pend[k] == 0) begin
          busy[k] = 0; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
        end else if (busy[k]) begin
          m_cyc[k] = 1'b1; m_stb[k] = (rem[k] > 0);
        end else if (jobs[k] > 0) begin
          busy[k] = 1; rem[k] = nreq; jobs[k]--; first_acc[k] = 1;
          m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
        end else begin
          m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
        end
        m_adr[k*12 +: 12] = madr[k];
      end
    end
    if (slave_auto) begin
      if (rsp_q.size() != 0 && rsp_q[0].due <= cur) begin
        wb_ack  = 1'b1;
        wb_rdat = rsp_q[0].dat;
        void'(rsp_q.pop_front());
      end else begin
        wb_ack  = 1'b0;
        wb_rdat = '0;
      end
    end
  endtask

  task automatic observe();
    exp_t e;
    if (slave_auto && wb_cyc && wb_stb && !wb_stall)
      rsp_q.push_back('{cur + slave_delay, rdata(wb_adr)});
    if (!auto_m) return;
    for (int k = 0; k < 2; k++) begin
      if (m_cyc[k] && m_stb[k] && !m_stall[k]) begin
        sb_q.push_back('{k, rdata(madr[k])});
        rem[k]--; pend[k]++; madr[k]++;
        acc_log.push_back(cur - base);
        if (first_acc[k]) begin
          grant_log.push_back(k);
          first_acc[k] = 0;
        end
      end
    end
    stall_log.push_back(m_stall[0]);
    check("stall_exclusive", 32'($countones(~m_stall)) <= 32'd1, 32'd1);
    if (m_ack != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {30'd0, m_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_ack_channel", {30'd0, m_ack}, 32'd1 << e.ch);
        check("sb_read_data", m_rdat, e.dat);
        pend[e.ch]--;
        ack_log.push_back(cur - base);
        $display("ack ch%0d data=%h cycle=%0d", e.ch, m_rdat, cur - base);
      end
    end
  endtask

  task automatic step();
    drive_all();
    @(negedge clk);
    observe();
    next();
  endtask

  task automatic run_auto(input int j0, input int j1, input int nr, input int dly);
    bit done;
    done = 0;
    base = cur;
    grant_log.delete(); acc_log.delete(); ack_log.delete(); stall_log.delete();
    sb_q.delete(); rsp_q.delete();
    jobs[0] = j0; jobs[1] = j1; nreq = nr; slave_delay = dly;
    madr[0] = 12'h100; madr[1] = 12'h200;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; pend[k] = 0; busy[k] = 0; first_acc[k] = 0;
    end
    auto_m = 1; slave_auto = 1;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      done = (jobs[0] == 0) && (jobs[1] == 0) && !busy[0] && !busy[1]
             && (sb_q.size() == 0) && (rsp_q.size() == 0);
    end
    check("auto_run_completed", {31'd0, done}, 32'd1);
    auto_m = 0; slave_auto = 0;
    m_cyc = 2'b00; m_stb = 2'b00; wb_ack = 1'b0; wb_rdat = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    m_cyc = 2'b00; m_stb = 2'b00; fp_cyc = 2'b00; fp_stb = 2'b00;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1,1'b1,1'b0,12'h010, 1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b11,2'b00,2'b00};
    vt[1]  = '{1'b1,1'b1,1'b0,12'h010, 1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,2'b10,2'b00,2'b00};
    vt[2]  = '{1'b1,1'b0,1'b0,12'h010, 1'b0,1'b1,1'b0,32'hDEADBEEF, 1'b1,1'b0,2'b10,2'b01,2'b00};
    vt[3]  = '{1'b1,1'b0,1'b0,12'h010, 1'b0,1'b1,1'b0,32'h0BADF00D, 1'b1,1'b0,2'b10,2'b00,2'b00};
    vt[4]  = '{1'b1,1'b1,1'b1,12'h020, 1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,2'b11,2'b00,2'b00};
    vt[5]  = '{1'b1,1'b1,1'b1,12'h020, 1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,2'b10,2'b00,2'b00};
    vt[6]  = '{1'b1,1'b1,1'b0,12'h021, 1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,2'b10,2'b00,2'b00};
    vt[7]  = '{1'b1,1'b1,1'b0,12'h022, 1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,2'b11,2'b00,2'b00};
    vt[8]  = '{1'b1,1'b1,1'b0,12'h022, 1'b0,1'b0,1'b1,32'h0,        1'b1,1'b0,2'b11,2'b00,2'b01};
    vt[9]  = '{1'b1,1'b1,1'b0,12'h022, 1'b0,1'b1,1'b0,32'hCAFE0001, 1'b1,1'b1,2'b10,2'b01,2'b00};
    vt[10] = '{1'b1,1'b0,1'b0,12'h022, 1'b0,1'b1,1'b0,32'hCAFE0002, 1'b1,1'b0,2'b10,2'b01,2'b00};
    vt[11] = '{1'b0,1'b0,1'b0,12'h022, 1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b10,2'b00,2'b00};
    vt[12] = '{1'b0,1'b0,1'b0,12'h022, 1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,2'b11,2'b00,2'b00};

    m_we = 2'b00; m_adr = '0;
    m_dat = {32'h55667788, 32'h11223344};
    m_sel = {4'h3, 4'hF};
    reset_dut();

    // Reset state
    @(negedge clk);
    check("reset.wb_cyc", {31'd0, wb_cyc}, 32'd0);
    check("reset.wb_stb", {31'd0, wb_stb}, 32'd0);
    check("reset.m_stall", {30'd0, m_stall}, 32'd3);
    check("reset.m_ack", {30'd0, m_ack}, 32'd0);
    check("reset.m_err", {30'd0, m_err}, 32'd0);
    next();

    // Single-master vector table on channel 0
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      m_cyc[0] = v.cyc0; m_stb[0] = v.stb0; m_we[0] = v.we0; m_adr[11:0] = v.adr0;
      wb_stall = v.wstall; wb_ack = v.wack; wb_err = v.werr; wb_rdat = v.wdat;
      @(negedge clk);
      check($sformatf("vec%0d.wb_cyc", i), {31'd0, wb_cyc}, {31'd0, v.e_cyc});
      check($sformatf("vec%0d.wb_stb", i), {31'd0, wb_stb}, {31'd0, v.e_stb});
      check($sformatf("vec%0d.m_stall", i), {30'd0, m_stall}, {30'd0, v.e_stall});
      check($sformatf("vec%0d.m_ack", i), {30'd0, m_ack}, {30'd0, v.e_ack});
      check($sformatf("vec%0d.m_err", i), {30'd0, m_err}, {30'd0, v.e_err});
      if (v.e_stb) begin
        check($sformatf("vec%0d.wb_adr", i), {20'd0, wb_adr}, {20'd0, v.adr0});
        check($sformatf("vec%0d.wb_we", i), {31'd0, wb_we}, {31'd0, v.we0});
        check($sformatf("vec%0d.wb_dat", i), wb_wdat, 32'h11223344);
        check($sformatf("vec%0d.wb_sel", i), {28'd0, wb_sel}, 32'hF);
      end
      if (v.e_ack != 2'b00)
        check($sformatf("vec%0d.m_dat", i), m_rdat, v.wdat);
      $display("vec%0d cyc=%b stb=%b stall=%b ack=%b err=%b", i, wb_cyc, wb_stb, m_stall, m_ack, m_err);
      next();
    end
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; m_we = 2'b00;

    // Error on the second of three requests, then abort with one outstanding
    m_cyc = 2'b01; m_stb = 2'b01; m_adr[11:0] = 12'h030;
    @(negedge clk); next();
    @(negedge clk);
    check("abort.first_stb", {31'd0, wb_stb}, 32'd1);
    check("abort.first_adr", {20'd0, wb_adr}, 32'h030);
    next();
    m_adr[11:0] = 12'h031; wb_ack = 1'b1; wb_rdat = 32'h11110000;
    @(negedge clk);
    check("abort.ack0", {30'd0, m_ack}, 32'd1);
    check("abort.ack0_dat", m_rdat, 32'h11110000);
    check("abort.no_err_yet", {30'd0, m_err}, 32'd0);
    next();
    m_adr[11:0] = 12'h032; wb_ack = 1'b0; wb_err = 1'b1;
    @(negedge clk);
    check("abort.err_pulse", {30'd0, m_err}, 32'd1);
    check("abort.err_no_ack", {30'd0, m_ack}, 32'd0);
    next();
    m_cyc = 2'b00; m_stb = 2'b00; wb_err = 1'b0;
    @(negedge clk);
    check("abort.err_once", {30'd0, m_err}, 32'd0);
    check("abort.cyc_drop", {31'd0, wb_cyc}, 32'd0);
    next();
    wb_ack = 1'b1;
    @(negedge clk);
    check("abort.late_ack_dropped", {30'd0, m_ack}, 32'd0);
    check("abort.idle_stall", {30'd0, m_stall}, 32'd3);
    next();
    wb_ack = 1'b0;
    $display("abort sequence done");

    // Round-robin fairness: both channels, two single-transfer jobs each
    reset_dut();
    run_auto(2, 2, 1, 1);
    check("rr.grant_count", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      check("rr.grant0", grant_log[0], 32'd0);
      check("rr.grant1", grant_log[1], 32'd1);
      check("rr.grant2", grant_log[2], 32'd0);
      check("rr.grant3", grant_log[3], 32'd1);
    end

    // Reset while channel 1 owns the bus with two outstanding
    next();
    m_cyc = 2'b10; m_stb = 2'b10; m_adr[23:12] = 12'h040;
    @(negedge clk); next();
    @(negedge clk);
    check("rst.ch1_granted", {30'd0, m_stall}, 32'd1);
    check("rst.ch1_adr", {20'd0, wb_adr}, 32'h040);
    next();
    m_adr[23:12] = 12'h041;
    @(negedge clk); next();
    m_stb = 2'b00; rst = 1'b1;
    @(negedge clk);
    check("rst.full_stall", {30'd0, m_stall}, 32'd3);
    next();
    rst = 1'b0; m_cyc = 2'b11;
    @(negedge clk);
    check("rst.wb_cyc_low", {31'd0, wb_cyc}, 32'd0);
    check("rst.all_stall", {30'd0, m_stall}, 32'd3);
    check("rst.no_ack", {30'd0, m_ack}, 32'd0);
    next();
    @(negedge clk);
    check("rst.ch0_first", {30'd0, m_stall}, 32'd2);
    check("rst.wb_cyc_high", {31'd0, wb_cyc}, 32'd1);
    next();
    m_cyc = 2'b00;

    // Outstanding limit: four back-to-back strobes, acks five cycles late
    reset_dut();
    run_auto(1, 0, 4, 5);
    check("lim.accepts", acc_log.size(), 32'd4);
    if (acc_log.size() == 4) begin
      check("lim.acc0_cycle", acc_log[0], 32'd1);
      check("lim.acc1_cycle", acc_log[1], 32'd2);
      check("lim.acc2_cycle", acc_log[2], 32'd7);
      check("lim.acc3_cycle", acc_log[3], 32'd8);
    end
    if (ack_log.size() > 0) check("lim.first_ack_cycle", ack_log[0], 32'd6);
    else check("lim.ack_seen", 32'd0, 32'd1);
    if (stall_log.size() > 7) begin
      for (int c = 3; c <= 6; c++)
        check($sformatf("lim.stall_c%0d", c), {31'd0, stall_log[c]}, 32'd1);
      check("lim.stall_c7", {31'd0, stall_log[7]}, 32'd0);
    end else begin
      check("lim.stall_log_len", stall_log.size(), 32'd8);
    end

    // Fixed priority instance
    reset_dut();
    fp_cyc = 2'b11; fp_stb = 2'b00;
    @(negedge clk);
    check("fp.idle_stall", {30'd0, fp_stall}, 32'd3);
    next();
    @(negedge clk);
    check("fp.ch0_wins", {30'd0, fp_stall}, 32'd2);
    check("fp.wb_cyc", {31'd0, fp_wcyc}, 32'd1);
    next();
    fp_cyc = 2'b10;
    @(negedge clk);
    check("fp.release_cyc", {31'd0, fp_wcyc}, 32'd0);
    next();
    fp_cyc = 2'b11;
    @(negedge clk);
    check("fp.idle_again", {30'd0, fp_stall}, 32'd3);
    next();
    @(negedge clk);
    check("fp.ch0_rewins", {30'd0, fp_stall}, 32'd2);
    next();
    fp_cyc = 2'b10;
    @(negedge clk); next();
    @(negedge clk); next();
    @(negedge clk);
    check("fp.ch1_after_drop", {30'd0, fp_stall}, 32'd1);
    check("fp.no_ack", {30'd0, fp_ack | fp_err}, 32'd0);
    next();
    fp_cyc = 2'b00;
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
